// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
//   Shared types and helpers for the FIFO stream adapter family (reader now,
//   writer blocks later).
//   - reader_state_t : drain-side state (RD_EMPTY = nothing held,
//                      RD_SERIAL = a word is held and being serialized)
//   - ratio_of()     : number of narrow beats per wide FIFO word
//   - idx_width()    : beat-index register width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

  typedef enum logic {
    RD_EMPTY  = 1'b0,
    RD_SERIAL = 1'b1
  } reader_state_t;

  function automatic int ratio_of(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction

  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clock   in   1      posedge clock
//     reset_n in   1      synchronous active-low clear
//     inc     in   1      count one event this cycle
//     count   out  WIDTH  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Drains a show-ahead FIFO (fifo_q valid whenever !fifo_empty, fifo_rdreq
//   pops) and serializes each IN_WIDTH word into IN_WIDTH/OUT_WIDTH beats on a
//   valid/ready stream, least-significant beat first. The next word is popped
//   in the same cycle the last beat is accepted, so back-to-back words stream
//   without a bubble.
//
//   Optional feature macro: FIFO_READER_STATS_EN adds saturating statistics
//   counters (stat_words, stat_stall). Without it those ports do not exist and
//   the datapath is unchanged.
//
//   Ports:
//     clock       in   1          posedge clock
//     reset_n     in   1          synchronous active-low reset
//     fifo_q      in   IN_WIDTH   FIFO head word
//     fifo_empty  in   1          FIFO empty
//     fifo_rdreq  out  1          pop FIFO head this cycle (combinational)
//     out_data    out  OUT_WIDTH  current beat
//     out_valid   out  1          beat valid
//     out_last    out  1          beat is the last of its word
//     out_ready   in   1          consumer accepts beat
//     flush       in   1          drop held word, return to RD_EMPTY
//     busy        out  1          a word is held (same as out_valid)
//     stat_words  out  CNT_WIDTH  words popped          (stats build only)
//     stat_stall  out  CNT_WIDTH  valid && !ready cycles (stats build only)
// -----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic                 busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_words,
  output logic [CNT_WIDTH-1:0] stat_stall
`endif
);

  localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W = idx_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || ((RATIO & (RATIO - 1)) != 0) || (CNT_WIDTH < 1))
  begin : g_param_check
    $error("fifo_stream_reader: illegal IN_WIDTH/OUT_WIDTH/CNT_WIDTH combination");
  end

  reader_state_t                     state;
  logic [IDX_W-1:0]                  idx;
  logic [RATIO-1:0][OUT_WIDTH-1:0]   hold;
  logic                              accept;
  logic                              at_last;

  assign at_last   = (idx == LAST_IDX);
  assign out_valid = (state == RD_SERIAL);
  assign busy      = out_valid;
  assign out_last  = out_valid && at_last;

  // A beat presented together with flush is dropped, not delivered.
  assign accept = out_valid && out_ready && !flush;

  // Pop when nothing is held, or when the final beat of the held word is
  // leaving this cycle; reset and flush both suppress the pop.
  assign fifo_rdreq = reset_n && !flush && !fifo_empty &&
                      ((state == RD_EMPTY) || (accept && at_last));

  if (RATIO == 1) begin : g_single_beat
    assign out_data = hold[0];
  end else begin : g_multi_beat
    assign out_data = hold[idx];
  end

  // NOTE: every register in this block is assigned with <=, so all of them
  // update together from the values they held before the clock edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RD_EMPTY;
      idx   <= '0;
      // NOTE: the hold register is cleared in reset so out_data reads zero
      // after reset; it is a single word, not a storage array.
      hold  <= '0;
    end else if (flush) begin
      state <= RD_EMPTY;
      idx   <= '0;
    end else if (fifo_rdreq) begin
      hold  <= fifo_q;
      idx   <= '0;
      state <= RD_SERIAL;
    end else if (accept) begin
      if (at_last) begin
        state <= RD_EMPTY;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic stall_cycle;
  assign stall_cycle = out_valid && !out_ready;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stat_words (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (fifo_rdreq),
    .count   (stat_words)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stat_stall (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall_cycle),
    .count   (stat_stall)
  );
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Self-checking bench for fifo_stream_reader (512b words, 64b beats).
//   The bench plays the show-ahead FIFO from a queue of words and keeps an
//   expected-beat queue: each popped word contributes its eight 64-bit slices
//   in LSB-first order, the last one flagged. Accepted beats must match that
//   queue in order; flush and reset discard the remainder of the held word.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int CNT_W = 32;
  localparam int RATIO = IN_W / OUT_W;

  typedef logic [IN_W-1:0]  word_t;
  typedef logic [OUT_W-1:0] beat_t;
  typedef struct packed {
    beat_t data;
    logic  last;
  } exp_beat_t;

  logic              clock;
  logic              reset_n;
  word_t             fifo_q;
  logic              fifo_empty;
  logic              fifo_rdreq;
  beat_t             out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              flush;
  logic              busy;
  logic [CNT_W-1:0]  stat_words;
  logic [CNT_W-1:0]  stat_stall;

  fifo_stream_reader #(
    .IN_WIDTH  (IN_W),
    .OUT_WIDTH (OUT_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .flush      (flush),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

`ifndef FIFO_READER_STATS_EN
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

  int checks   = 0;
  int failures = 0;

  word_t     fifo_mdl[$];
  exp_beat_t exp_q[$];
  int        mdl_words = 0;
  int        mdl_stall = 0;
  int        acc_cnt   = 0;

  logic  obs_valid, obs_rdreq, obs_last;
  beat_t obs_data;
  logic  prev_stall = 1'b0;
  beat_t prev_data;
  logic  prev_last;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic word_t counting_word();
    word_t w;
    for (int k = 0; k < RATIO; k++) w[k*OUT_W +: OUT_W] = beat_t'(k);
    return w;
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample and score
  // before the rising edge, then let the FIFO model retire a popped word.
  task automatic step(input logic rdy, input logic fl, input logic rst);
    logic      pop;
    exp_beat_t e;
    reset_n    = rst;
    out_ready  = rdy;
    flush      = fl;
    fifo_empty = (fifo_mdl.size() == 0);
    fifo_q     = fifo_empty ? rand_word() : fifo_mdl[0];
    #1;
    obs_valid = out_valid;
    obs_rdreq = fifo_rdreq;
    obs_data  = out_data;
    obs_last  = out_last;

    checks++;
    if ((fifo_empty || !rst || fl) && (fifo_rdreq !== 1'b0)) begin
      failures++;
      $display("FAIL rdreq_illegal: rdreq=%b with empty=%b reset_n=%b flush=%b, required 0",
               fifo_rdreq, fifo_empty, rst, fl);
    end

    if (!rst) begin
      exp_q.delete();
      mdl_words  = 0;
      mdl_stall  = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (busy !== out_valid) begin
        failures++;
        $display("FAIL busy: busy=%b, required %b (out_valid)", busy, out_valid);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL valid: out_valid=%b, required %b (beats pending=%0d)",
                 out_valid, (exp_q.size() != 0), exp_q.size());
      end
      if (prev_stall) begin
        checks++;
        if ((out_data !== prev_data) || (out_last !== prev_last)) begin
          failures++;
          $display("FAIL stable: data=%h last=%b after stall, required data=%h last=%b",
                   out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && rdy && !fl) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat: got unexpected beat data=%h, required no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if ((out_data !== e.data) || (out_last !== e.last)) begin
            failures++;
            $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
      if (fl) exp_q.delete();
      if (out_valid && !rdy) mdl_stall++;
      if (fifo_rdreq === 1'b1) begin
        mdl_words++;
        for (int k = 0; k < RATIO; k++)
          exp_q.push_back('{data: fifo_q[k*OUT_W +: OUT_W], last: (k == RATIO - 1)});
      end
      prev_stall = out_valid && !rdy && !fl;
      prev_data  = out_data;
      prev_last  = out_last;
    end

    pop = (fifo_rdreq === 1'b1);
    @(posedge clock);
    if (pop) void'(fifo_mdl.pop_front());
    @(negedge clock);
  endtask

  // mode 0: always ready; 1: random ready; 2: ready pattern 1,0,0,1,0,1,...;
  // 3: random ready with occasional flush.
  task automatic drain(input int max_cycles, input int mode);
    logic [5:0] pat = 6'b101001;
    int         n   = 0;
    logic       rdy, fl;
    while (((fifo_mdl.size() != 0) || (exp_q.size() != 0)) && (n < max_cycles)) begin
      fl = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = pat[n % 6];
        3: begin
          rdy = 1'($urandom_range(0, 1));
          fl  = ($urandom_range(0, 15) == 0);
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      step(rdy, fl, 1'b1);
      n++;
    end
    checks++;
    if ((fifo_mdl.size() != 0) || (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL drain_timeout: %0d words and %0d beats left after %0d cycles, required 0",
               fifo_mdl.size(), exp_q.size(), n);
    end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    fifo_mdl.push_back(rand_word());
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    checks++;
    if ((obs_rdreq !== 1'b0) || (obs_valid !== 1'b0) || (obs_last !== 1'b0) ||
        (obs_data !== '0) || (busy !== 1'b0)) begin
      failures++;
      $display("FAIL reset_outputs: rdreq=%b valid=%b last=%b busy=%b data=%h, required all 0",
               obs_rdreq, obs_valid, obs_last, busy, obs_data);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if ((stat_words !== '0) || (stat_stall !== '0)) begin
      failures++;
      $display("FAIL reset_stats: words=%0d stall=%0d, required 0 and 0", stat_words, stat_stall);
    end
`endif
    fifo_mdl.delete();
  endtask

  task automatic test_single_word();
    int acc0 = acc_cnt;
    fifo_mdl.push_back(counting_word());
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_rdreq !== 1'b1) || (obs_valid !== 1'b0)) begin
      failures++;
      $display("FAIL single_pop: rdreq=%b valid=%b, required 1 and 0", obs_rdreq, obs_valid);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_valid !== 1'b1) || (obs_data !== beat_t'(0)) || (obs_rdreq !== 1'b0)) begin
      failures++;
      $display("FAIL single_latency: valid=%b data=%h rdreq=%b, required 1, 0, 0",
               obs_valid, obs_data, obs_rdreq);
    end
    drain(40, 0);
    checks++;
    if (acc_cnt - acc0 != RATIO) begin
      failures++;
      $display("FAIL single_beats: %0d beats accepted, required %0d", acc_cnt - acc0, RATIO);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if ((stat_words !== CNT_W'(1)) || (stat_stall !== '0)) begin
      failures++;
      $display("FAIL single_stats: words=%0d stall=%0d, required 1 and 0", stat_words, stat_stall);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int   nvalid = 0;
    logic rd7    = 1'b0;
    int   stall0 = mdl_stall;
    fifo_mdl.push_back(rand_word());
    fifo_mdl.push_back(rand_word());
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_rdreq !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_pop: rdreq=%b, required 1", obs_rdreq);
    end
    for (int i = 0; i < 2 * RATIO; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (obs_valid === 1'b1) nvalid++;
      if (i == RATIO - 1) rd7 = obs_rdreq;
    end
    checks++;
    if ((nvalid != 2 * RATIO) || (rd7 !== 1'b1)) begin
      failures++;
      $display("FAIL b2b_no_bubble: %0d valid cycles, rdreq on last beat=%b, required %0d and 1",
               nvalid, rd7, 2 * RATIO);
    end
    drain(10, 0);
`ifdef FIFO_READER_STATS_EN
    checks++;
    if ((stat_words !== CNT_W'(mdl_words)) || (stat_stall !== CNT_W'(stall0))) begin
      failures++;
      $display("FAIL b2b_stats: words=%0d stall=%0d, required %0d and %0d",
               stat_words, stat_stall, mdl_words, stall0);
    end
`endif
  endtask

  task automatic test_stall_pattern();
    for (int i = 0; i < 3; i++) fifo_mdl.push_back(rand_word());
    drain(400, 2);
`ifdef FIFO_READER_STATS_EN
    checks++;
    if ((stat_stall !== CNT_W'(mdl_stall)) || (stat_words !== CNT_W'(mdl_words))) begin
      failures++;
      $display("FAIL stall_stats: stall=%0d words=%0d, required %0d and %0d",
               stat_stall, stat_words, mdl_stall, mdl_words);
    end
`endif
  endtask

  task automatic test_flush();
    word_t b = rand_word();
    fifo_mdl.push_back(counting_word());
    fifo_mdl.push_back(b);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if ((obs_valid !== 1'b1) || (obs_data !== beat_t'(3)) || (obs_rdreq !== 1'b0)) begin
      failures++;
      $display("FAIL flush_cycle: valid=%b data=%h rdreq=%b, required 1, 3, 0",
               obs_valid, obs_data, obs_rdreq);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_valid !== 1'b0) || (obs_rdreq !== 1'b1)) begin
      failures++;
      $display("FAIL flush_after: valid=%b rdreq=%b, required 0 and 1", obs_valid, obs_rdreq);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_valid !== 1'b1) || (obs_data !== b[OUT_W-1:0])) begin
      failures++;
      $display("FAIL flush_next_word: valid=%b data=%h, required 1 and %h",
               obs_valid, obs_data, b[OUT_W-1:0]);
    end
    drain(40, 0);
  endtask

  task automatic test_reset_mid_word();
    word_t a = rand_word();
    word_t b = rand_word();
    fifo_mdl.push_back(a);
    fifo_mdl.push_back(b);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ((obs_valid !== 1'b1) || (obs_data !== a[5*OUT_W +: OUT_W])) begin
      failures++;
      $display("FAIL rst_mid_beat5: valid=%b data=%h, required 1 and %h",
               obs_valid, obs_data, a[5*OUT_W +: OUT_W]);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ((obs_valid !== 1'b0) || (obs_data !== '0) || (stat_words !== '0) || (stat_stall !== '0)) begin
      failures++;
      $display("FAIL rst_mid_after: valid=%b data=%h words=%0d stall=%0d, required all 0",
               obs_valid, obs_data, stat_words, stat_stall);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_rdreq !== 1'b1) || (fifo_q !== b)) begin
      failures++;
      $display("FAIL rst_mid_repop: rdreq=%b, required 1 with the untouched next word at head",
               obs_rdreq);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if ((obs_valid !== 1'b1) || (obs_data !== b[OUT_W-1:0])) begin
      failures++;
      $display("FAIL rst_mid_restart: valid=%b data=%h, required 1 and %h",
               obs_valid, obs_data, b[OUT_W-1:0]);
    end
    drain(40, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) fifo_mdl.push_back(rand_word());
      drain(800, (r % 2 == 0) ? 1 : 3);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if ((stat_words !== CNT_W'(mdl_words)) || (stat_stall !== CNT_W'(mdl_stall))) begin
      failures++;
      $display("FAIL random_stats: words=%0d stall=%0d, required %0d and %0d",
               stat_words, stat_stall, mdl_words, mdl_stall);
    end
`endif
  endtask

  initial begin
    reset_n    = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    fifo_q     = '0;
    @(negedge clock);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall_pattern();
    test_flush();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
